// File: rtl/countdown_timer_pkg.sv
// Shared types and defaults for the countdown timer slice.
package countdown_pkg;

    localparam int DEFAULT_WIDTH      = 4;
    localparam int DEFAULT_PRESCALE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/countdown_timer_tick_prescaler.sv
// Prescale divider: emits one tick every prescale+1 enabled cycles.
// The >= compare means lowering prescale below the running count still
// produces a tick on the next enabled cycle instead of waiting for a wrap.
module tick_prescaler
    import countdown_pkg::*;
#(
    parameter int PRESCALE_W = DEFAULT_PRESCALE_W
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clr_i,
    input  logic                  enable_i,
    input  logic [PRESCALE_W-1:0] prescale_i,
    output logic                  tick_o
);

    logic [PRESCALE_W-1:0] pre_cnt_q;
    logic [PRESCALE_W-1:0] pre_cnt_d;

    // Next divider value and tick; clr forces zero and suppresses the tick.
    always_comb begin
        pre_cnt_d = pre_cnt_q;
        tick_o    = 1'b0;
        if (clr_i) begin
            pre_cnt_d = '0;
        end else if (enable_i) begin
            if (pre_cnt_q >= prescale_i) begin
                tick_o    = 1'b1;
                pre_cnt_d = '0;
            end else begin
                pre_cnt_d = pre_cnt_q + PRESCALE_W'(1);
            end
        end
    end

    // Divider register with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            pre_cnt_q <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter with prescaler, one-shot or auto-reload expiry,
// a sticky underflow flag and a one-cycle expire pulse.
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int PRESCALE_W = DEFAULT_PRESCALE_W
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load_i,
    input  logic [WIDTH-1:0]      load_value_i,
    input  logic                  enable_i,
    input  logic                  auto_reload_i,
    input  logic [PRESCALE_W-1:0] prescale_i,
    input  logic                  clear_underflow_i,
    output logic [WIDTH-1:0]      count_o,
    output logic                  underflow_o,
    output logic                  expire_o,
    output logic                  busy_o
);

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] reload_q;
    logic [WIDTH-1:0] reload_d;
    logic             underflow_q;
    logic             underflow_d;
    logic             expire_q;
    logic             expire_d;
    logic             tick;
    logic             pre_clr;

    // The divider only runs in RUN, and a load restarts it from zero so any
    // tick due in the load cycle is dropped.
    assign pre_clr = load_i || (state_q != RUN);

    tick_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clock      (clock),
        .reset      (reset),
        .clr_i      (pre_clr),
        .enable_i   (enable_i),
        .prescale_i (prescale_i),
        .tick_o     (tick)
    );

    // Next-state logic: load beats tick; expiry sets underflow over a clear.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        reload_d    = reload_q;
        expire_d    = 1'b0;
        underflow_d = clear_underflow_i ? 1'b0 : underflow_q;
        if (load_i) begin
            count_d  = load_value_i;
            reload_d = load_value_i;
            state_d  = RUN;
        end else if (tick && (state_q == RUN)) begin
            if (count_q != '0) begin
                count_d = count_q - WIDTH'(1);
            end else begin
                expire_d    = 1'b1;
                underflow_d = 1'b1;
                if (auto_reload_i) begin
                    count_d = reload_q;
                end else begin
                    state_d = DONE;
                end
            end
        end
    end

    // State, count, reload value and flags, all with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            count_q     <= '0;
            reload_q    <= '0;
            underflow_q <= 1'b0;
            expire_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            reload_q    <= reload_d;
            underflow_q <= underflow_d;
            expire_q    <= expire_d;
        end
    end

    assign count_o     = count_q;
    assign underflow_o = underflow_q;
    assign expire_o    = expire_q;
    assign busy_o      = (state_q == RUN);

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: stimulus pushes cycle-tagged
// expected outputs, a negedge monitor pops and compares them.
module tb_countdown_timer;

    logic       clock;
    logic       reset;
    logic       load;
    logic [3:0] loadValue;
    logic       enable;
    logic       autoReload;
    logic [3:0] prescale;
    logic       clearUnderflow;
    logic [3:0] count;
    logic       underflow;
    logic       expire;
    logic       busy;

    typedef struct {
        int         cyc;
        logic [3:0] cnt;
        logic       uf;
        logic       ex;
        logic       bz;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   base;

    countdown_timer #(
        .WIDTH      (4),
        .PRESCALE_W (4)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .load_i            (load),
        .load_value_i      (loadValue),
        .enable_i          (enable),
        .auto_reload_i     (autoReload),
        .prescale_i        (prescale),
        .clear_underflow_i (clearUnderflow),
        .count_o           (count),
        .underflow_o       (underflow),
        .expire_o          (expire),
        .busy_o            (busy)
    );

    // Free-running clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Cycle index: value N means the outputs seen now follow the N-th edge.
    always @(posedge clock) cyc <= cyc + 1;

    task automatic pushExp(input int c, input logic [3:0] cnt, input logic uf,
                           input logic ex, input logic bz);
        exp_t e;
        e.cyc = c;
        e.cnt = cnt;
        e.uf  = uf;
        e.ex  = ex;
        e.bz  = bz;
        sb.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        checks++;
        if (count !== e.cnt || underflow !== e.uf || expire !== e.ex || busy !== e.bz) begin
            failures++;
            $display("[TB] FAIL outputs@cyc%0d: got count=%0d underflow=%b expire=%b busy=%b, expected count=%0d underflow=%b expire=%b busy=%b",
                     e.cyc, count, underflow, expire, busy, e.cnt, e.uf, e.ex, e.bz);
        end
    endtask

    // Monitor: compare every expectation tagged with the current cycle.
    always @(negedge clock) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            cur = sb.pop_front();
            if (cur.cyc < cyc) begin
                checks++;
                failures++;
                $display("[TB] FAIL stale@cyc%0d: expectation not checked, now cycle %0d", cur.cyc, cyc);
            end else begin
                checkOutput(cur);
            end
        end
    end

    task automatic applyStimulus(input logic ld, input logic [3:0] lv, input logic ar,
                                 input logic clr, input logic en, input logic [3:0] ps,
                                 input logic rst);
        load           = ld;
        loadValue      = lv;
        autoReload     = ar;
        clearUnderflow = clr;
        enable         = en;
        prescale       = ps;
        reset          = rst;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    // One-shot with load_value=3, prescale=0 loaded in cycle b.
    task automatic expectOneShot3(input int b);
        pushExp(b + 1, 4'd3, 1'b0, 1'b0, 1'b1);
        pushExp(b + 2, 4'd2, 1'b0, 1'b0, 1'b1);
        pushExp(b + 3, 4'd1, 1'b0, 1'b0, 1'b1);
        pushExp(b + 4, 4'd0, 1'b0, 1'b0, 1'b1);
        pushExp(b + 5, 4'd0, 1'b1, 1'b1, 1'b0);
        pushExp(b + 6, 4'd0, 1'b1, 1'b0, 1'b0);
        pushExp(b + 7, 4'd0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
        step(1);
        pushExp(cyc + 1, 4'd0, 1'b0, 1'b0, 1'b0);
        step(1);

        $display("[TB] basic one-shot");
        base = cyc;
        applyStimulus(1'b1, 4'd3, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0);
        expectOneShot3(base);
        step(1);
        load = 1'b0;
        step(7);

        $display("[TB] clear underflow outside expiry");
        base = cyc;
        clearUnderflow = 1'b1;
        pushExp(base + 1, 4'd0, 1'b0, 1'b0, 1'b0);
        step(1);
        clearUnderflow = 1'b0;

        $display("[TB] prescale 2");
        base = cyc;
        applyStimulus(1'b1, 4'd1, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0);
        for (int i = 1; i <= 3; i++) pushExp(base + i, 4'd1, 1'b0, 1'b0, 1'b1);
        for (int i = 4; i <= 6; i++) pushExp(base + i, 4'd0, 1'b0, 1'b0, 1'b1);
        pushExp(base + 7, 4'd0, 1'b1, 1'b1, 1'b0);
        step(1);
        load = 1'b0;
        step(6);

        $display("[TB] prescale 2 with enable gap, reload from DONE");
        base = cyc;
        load = 1'b1;
        for (int i = 1; i <= 7; i++) pushExp(base + i, 4'd1, 1'b1, 1'b0, 1'b1);
        for (int i = 8; i <= 10; i++) pushExp(base + i, 4'd0, 1'b1, 1'b0, 1'b1);
        pushExp(base + 11, 4'd0, 1'b1, 1'b1, 1'b0);
        pushExp(base + 12, 4'd0, 1'b1, 1'b0, 1'b0);
        step(1);
        load = 1'b0;
        step(1);
        enable = 1'b0;
        step(4);
        enable = 1'b1;
        step(6);

        $display("[TB] auto-reload, flag handling, load priority, reset");
        base = cyc;
        applyStimulus(1'b1, 4'd2, 1'b1, 1'b1, 1'b1, 4'd0, 1'b0);
        pushExp(base + 1, 4'd2, 1'b0, 1'b0, 1'b1);
        pushExp(base + 2, 4'd1, 1'b0, 1'b0, 1'b1);
        pushExp(base + 3, 4'd0, 1'b0, 1'b0, 1'b1);
        pushExp(base + 4, 4'd2, 1'b1, 1'b1, 1'b1);
        pushExp(base + 5, 4'd1, 1'b1, 1'b0, 1'b1);
        pushExp(base + 6, 4'd0, 1'b1, 1'b0, 1'b1);
        pushExp(base + 7, 4'd2, 1'b1, 1'b1, 1'b1);
        pushExp(base + 8, 4'd1, 1'b0, 1'b0, 1'b1);
        pushExp(base + 9, 4'd5, 1'b0, 1'b0, 1'b1);
        pushExp(base + 10, 4'd4, 1'b0, 1'b0, 1'b1);
        pushExp(base + 11, 4'd3, 1'b0, 1'b0, 1'b1);
        pushExp(base + 12, 4'd2, 1'b0, 1'b0, 1'b1);
        pushExp(base + 13, 4'd1, 1'b0, 1'b0, 1'b1);
        pushExp(base + 14, 4'd0, 1'b0, 1'b0, 1'b1);
        pushExp(base + 15, 4'd0, 1'b1, 1'b1, 1'b0);
        pushExp(base + 16, 4'd0, 1'b1, 1'b0, 1'b0);
        pushExp(base + 17, 4'd2, 1'b1, 1'b0, 1'b1);
        pushExp(base + 18, 4'd1, 1'b1, 1'b0, 1'b1);
        pushExp(base + 19, 4'd0, 1'b1, 1'b0, 1'b1);
        pushExp(base + 20, 4'd2, 1'b1, 1'b1, 1'b1);
        pushExp(base + 21, 4'd0, 1'b0, 1'b0, 1'b0);
        step(1);
        load = 1'b0;
        clearUnderflow = 1'b0;
        step(5);
        clearUnderflow = 1'b1;
        step(1);
        clearUnderflow = 1'b1;
        step(1);
        clearUnderflow = 1'b0;
        load = 1'b1;
        loadValue = 4'd5;
        step(1);
        load = 1'b0;
        step(1);
        autoReload = 1'b0;
        step(6);
        load = 1'b1;
        loadValue = 4'd2;
        autoReload = 1'b1;
        step(1);
        load = 1'b0;
        step(3);
        reset = 1'b1;
        step(1);

        $display("[TB] load right after reset");
        base = cyc;
        applyStimulus(1'b1, 4'd3, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0);
        expectOneShot3(base);
        step(1);
        load = 1'b0;
        step(9);

        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Loadable down-counter/timer; the decrementing counterpart of the team's up-counter with overflow flag.
- Counts from a loaded value down to zero at a programmable prescaled rate, then flags underflow.
- Supports one-shot or auto-reload operation.
- Sits beside the up-counter in control paths: watchdogs, timeouts, periodic event generation.

Parameters:
- WIDTH, 4, width of count and load value.
- PRESCALE_W, 4, width of the prescale divider setting.

Ports:
- clock  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- load  input  1  load load_value and start timer
- load_value  input  WIDTH  start and reload value
- enable  input  1  advance the prescaler; low freezes the timer
- auto_reload  input  1  1 = reload on expiry, 0 = one-shot
- prescale  input  PRESCALE_W  one decrement per prescale+1 enabled cycles
- clear_underflow  input  1  clear the sticky underflow flag
- count  output  WIDTH  current count, registered
- underflow  output  1  sticky flag, set on expiry
- expire  output  1  one-cycle pulse on expiry
- busy  output  1  high while in state RUN

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clock.
- Reset values: count=0, underflow=0, expire=0, busy=0, state=IDLE, prescale counter pre_cnt=0, reload register=0.
- All outputs are registered and change one cycle after the causing input edge.
- Priority, highest first: reset, then load, then tick processing.
- States:
  - IDLE: waiting for load.
  - RUN: counting; busy=1.
  - DONE: expired in one-shot mode; count holds 0; only load leaves DONE.
- load (any state):
  - count<=load_value, reload register<=load_value, pre_cnt<=0, state<=RUN.
  - An in-flight tick is discarded; no expire pulse in that cycle.
  - load_value=0 is legal: the timer expires on the first tick.
- Prescaler (RUN only):
  - When enable=1: if pre_cnt>=prescale then tick=1 and pre_cnt<=0, else pre_cnt<=pre_cnt+1.
  - When enable=0: pre_cnt and count hold.
  - prescale is sampled live. The >= compare guarantees a tick if prescale is lowered below pre_cnt.
- Tick in RUN:
  - count!=0: count<=count-1, modulo 2^WIDTH with no wrap possible.
  - count==0 (expiry): expire<=1 for one cycle, underflow<=1.
    - auto_reload=1: count<=reload register, stay in RUN.
    - auto_reload=0: count stays 0, state<=DONE.
- Period: load_value+1 ticks per expiry, i.e. (load_value+1)*(prescale+1) enabled cycles.
- clear_underflow: underflow<=0. If it coincides with an expiry, set wins (underflow=1).
- expire is 0 in every cycle with no expiry.
- Reset asserted mid-count returns to reset values on the next edge with no expire pulse.
- auto_reload is sampled at the expiry tick; changing it mid-count is legal.
- In IDLE and DONE: enable and prescale are ignored and pre_cnt holds 0.

Decomposition:
- Package countdown_pkg:
  - State enum: IDLE, RUN, DONE.
  - Default WIDTH and PRESCALE_W localparams.
- Sub-module tick_prescaler:
  - Holds pre_cnt and the compare; emits the tick.
  - Inputs: clock, reset, clr (driven by load or not-RUN), enable, prescale.
- The top level holds the FSM, count, reload register and flags.

Test Plan:
- Basic one-shot:
  - Stimulus: prescale=0, enable=1, auto_reload=0, load=1 with load_value=3 at cycle 0.
  - Response: count 3,2,1,0 at cycles 1-4; expire=1 and underflow=1 at cycle 5 only; busy=0 and count=0 from cycle 5 onward.
- Prescale:
  - Stimulus: prescale=2, load_value=1.
  - Response: count decrements every 3 enabled cycles; expire 6 cycles after the first RUN cycle. Dropping enable for 4 cycles mid-count delays expire by exactly 4.
- Auto-reload:
  - Stimulus: load_value=2, prescale=0, auto_reload=1.
  - Response: expire pulses every 3 cycles; count sequence 2,1,0,2,1,0; busy stays 1.
- Flag handling:
  - Stimulus 1: clear_underflow pulsed in a non-expiry cycle. Response: underflow=0 next cycle.
  - Stimulus 2: clear_underflow pulsed in the same cycle as an expiry. Response: underflow=1.
- Load priority and restart:
  - Stimulus: load_value=5 applied when count=1 and a tick is due.
  - Response: count=5, no expire. Loading from DONE restarts with busy=1.
- Reset mid-operation:
  - Stimulus: reset asserted while count=2 in RUN with underflow=1.
  - Response: next cycle count=0, underflow=0, busy=0, expire=0. A load right after reset behaves exactly as in the basic one-shot case.
